// File: rtl/cache_bus_arb.sv
// Arbiter between the D$ and I$ line-fill/evict ports and a single beat-serial bus.
// Bursts run to completion once granted; a tie in IDLE goes to whichever side was not granted last.
module cache_bus_arb #(
    parameter int PA_BITS      = 32,
    parameter int LOGBWPL      = 3,
    parameter int LOGBEATBYTES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         DCacheBusRW_i,
    input  logic [PA_BITS-1:0] DCacheBusAdr_i,
    output logic               DCacheBusAck_o,
    input  logic [1:0]         IFUCacheBusRW_i,
    input  logic [PA_BITS-1:0] IFUCacheBusAdr_i,
    output logic               IFUCacheBusAck_o,
    input  logic               IFUFlushStage_i,
    output logic [1:0]         BusRW_o,
    output logic [PA_BITS-1:0] BusAdr_o,
    input  logic               BusBeatReady_i,
    output logic [LOGBWPL-1:0] BeatCount_o,
    output logic               BusLast_o,
    output logic               GrantD_o,
    output logic               GrantI_o
);
    localparam int OFFSETLEN = LOGBWPL + LOGBEATBYTES;
    localparam int LINE_BITS = PA_BITS - OFFSETLEN;

    typedef enum logic [1:0] {S_IDLE, S_DBURST, S_IBURST, S_ACK} state_e;

    state_e               state_q, state_d;
    logic [LOGBWPL-1:0]   beat_q, beat_d;
    logic                 last_grant_i_q, last_grant_i_d;
    logic [1:0]           rw_q, rw_d;
    logic [LINE_BITS-1:0] line_q, line_d;

    logic d_pend, i_pend, in_burst, bus_last;
    logic unused_offset_bits;

    assign d_pend   = |DCacheBusRW_i;
    assign i_pend   = (|IFUCacheBusRW_i) & ~IFUFlushStage_i;
    assign in_burst = (state_q == S_DBURST) || (state_q == S_IBURST);
    assign bus_last = in_burst && (beat_q == '1);

    // Line offsets are regenerated from the beat counter, so the requesters' low bits are dropped.
    assign unused_offset_bits = ^{DCacheBusAdr_i[OFFSETLEN-1:0], IFUCacheBusAdr_i[OFFSETLEN-1:0]};

    // NOTE: state is only ever written with non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            last_grant_i_q <= 1'b1;
            rw_q           <= '0;
            line_q         <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            last_grant_i_q <= last_grant_i_d;
            rw_q           <= rw_d;
            line_q         <= line_d;
        end
    end

    // NOTE: every combinational output is given a default first; a path that leaves one
    // unassigned would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        last_grant_i_d = last_grant_i_q;
        rw_d           = rw_q;
        line_d         = line_q;
        unique case (state_q)
            S_IDLE: begin
                if (d_pend && (!i_pend || last_grant_i_q)) begin
                    state_d        = S_DBURST;
                    rw_d           = DCacheBusRW_i;
                    line_d         = DCacheBusAdr_i[PA_BITS-1:OFFSETLEN];
                    last_grant_i_d = 1'b0;
                end else if (i_pend) begin
                    state_d        = S_IBURST;
                    rw_d           = IFUCacheBusRW_i;
                    line_d         = IFUCacheBusAdr_i[PA_BITS-1:OFFSETLEN];
                    last_grant_i_d = 1'b1;
                end
            end
            S_DBURST, S_IBURST: begin
                // The counter wraps to zero on its own after the final beat.
                if (BusBeatReady_i) begin
                    beat_d = beat_q + 1'b1;
                    if (bus_last) state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BusRW_o          = '0;
        BusAdr_o         = '0;
        GrantD_o         = 1'b0;
        GrantI_o         = 1'b0;
        BusLast_o        = 1'b0;
        DCacheBusAck_o   = 1'b0;
        IFUCacheBusAck_o = 1'b0;
        BeatCount_o      = beat_q;
        unique case (state_q)
            S_DBURST, S_IBURST: begin
                BusRW_o   = rw_q;
                BusAdr_o  = {line_q, beat_q, {LOGBEATBYTES{1'b0}}};
                GrantD_o  = (state_q == S_DBURST);
                GrantI_o  = (state_q == S_IBURST);
                BusLast_o = bus_last;
            end
            S_ACK: begin
                // last_grant_i_q still names the owner of the burst that just finished.
                GrantD_o         = ~last_grant_i_q;
                GrantI_o         = last_grant_i_q;
                DCacheBusAck_o   = ~last_grant_i_q;
                IFUCacheBusAck_o = last_grant_i_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_bus_arb.sv
// Scoreboard bench for cache_bus_arb: expected beats are queued when a request is driven
// and compared beat by beat as the bus accepts them.
module tb_cache_bus_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  d_rw, i_rw, bus_rw;
    logic [31:0] d_adr, i_adr, bus_adr;
    logic        flush, ready;
    logic        d_ack, i_ack, grant_d, grant_i, bus_last;
    logic [2:0]  beat_cnt;
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic [1:0]  rw;
        logic [31:0] adr;
        logic        gd;
        logic        gi;
        logic        last;
        logic [2:0]  beat;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    cache_bus_arb dut (
        .clk              (clk),
        .reset            (reset),
        .DCacheBusRW_i    (d_rw),
        .DCacheBusAdr_i   (d_adr),
        .DCacheBusAck_o   (d_ack),
        .IFUCacheBusRW_i  (i_rw),
        .IFUCacheBusAdr_i (i_adr),
        .IFUCacheBusAck_o (i_ack),
        .IFUFlushStage_i  (flush),
        .BusRW_o          (bus_rw),
        .BusAdr_o         (bus_adr),
        .BusBeatReady_i   (ready),
        .BeatCount_o      (beat_cnt),
        .BusLast_o        (bus_last),
        .GrantD_o         (grant_d),
        .GrantI_o         (grant_i)
    );

    function automatic beat_t observe();
        beat_t o;
        o.rw   = bus_rw;
        o.adr  = bus_adr;
        o.gd   = grant_d;
        o.gi   = grant_i;
        o.last = bus_last;
        o.beat = beat_cnt;
        return o;
    endfunction

    task automatic push_line(input logic gi, input logic [1:0] rw, input logic [31:0] adr);
        for (int b = 0; b < 8; b++) begin
            beat_t e;
            e.rw   = rw;
            e.adr  = {adr[31:6], 3'(b), 3'b000};
            e.gd   = ~gi;
            e.gi   = gi;
            e.last = (b == 7);
            e.beat = 3'(b);
            sb.push_back(e);
        end
    endtask

    // Entered on the negedge where the burst's first beat must already be on the bus.
    task automatic expect_burst(input string name, input int stall_beat, input int stall_len,
                                input int flush_beat);
        int    stalls   = stall_len;
        int    accepted = 0;
        int    cycles   = 0;
        logic  gi;
        beat_t exp, obs;
        if (sb.size() < 8) begin
            total++; bad++;
            $display("FAIL %s queue: has %0d entries, required 8", name, sb.size());
            return;
        end
        gi = sb[0].gi;
        while (accepted < 8 && cycles < 40) begin
            exp = sb[0];
            obs = observe();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s beat%0d: got rw=%b adr=%h gd=%b gi=%b last=%b cnt=%0d, required rw=%b adr=%h gd=%b gi=%b last=%b cnt=%0d",
                         name, exp.beat, obs.rw, obs.adr, obs.gd, obs.gi, obs.last, obs.beat,
                         exp.rw, exp.adr, exp.gd, exp.gi, exp.last, exp.beat);
            end
            // The owner withdraws its request after the first beat; the burst must carry on.
            if (accepted == 0) begin
                if (gi) i_rw = 2'b00;
                else    d_rw = 2'b00;
            end
            if (int'(exp.beat) == flush_beat) flush = 1'b1;
            if (int'(exp.beat) == stall_beat && stalls > 0) begin
                ready = 1'b0;
                stalls--;
            end else begin
                ready = 1'b1;
                void'(sb.pop_front());
                accepted++;
            end
            @(negedge clk);
            cycles++;
        end
        ready = 1'b0;
        total++;
        if (bus_rw !== 2'b00 || d_ack !== ~gi || i_ack !== gi || grant_d !== ~gi || grant_i !== gi) begin
            bad++;
            $display("FAIL %s ack: got rw=%b dack=%b iack=%b gd=%b gi=%b, required rw=00 dack=%b iack=%b gd=%b gi=%b",
                     name, bus_rw, d_ack, i_ack, grant_d, grant_i, ~gi, gi, ~gi, gi);
        end
        @(negedge clk);
        total++;
        if (bus_rw !== 2'b00 || bus_adr !== 32'h0 || d_ack || i_ack || grant_d || grant_i || bus_last) begin
            bad++;
            $display("FAIL %s idle: got rw=%b adr=%h dack=%b iack=%b gd=%b gi=%b last=%b, required all zero",
                     name, bus_rw, bus_adr, d_ack, i_ack, grant_d, grant_i, bus_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus_rw !== 2'b00) begin bad++; $display("FAIL reset_busrw: got %b, required 00", bus_rw); end
        total++;
        if (d_ack !== 1'b0 || i_ack !== 1'b0) begin
            bad++; $display("FAIL reset_acks: got d=%b i=%b, required 0 0", d_ack, i_ack);
        end
        total++;
        if (grant_d !== 1'b0 || grant_i !== 1'b0) begin
            bad++; $display("FAIL reset_grants: got d=%b i=%b, required 0 0", grant_d, grant_i);
        end
        total++;
        if (beat_cnt !== 3'd0) begin bad++; $display("FAIL reset_beatcount: got %0d, required 0", beat_cnt); end
        total++;
        if (bus_adr !== 32'h0 || bus_last !== 1'b0) begin
            bad++; $display("FAIL reset_adr: got adr=%h last=%b, required 0 0", bus_adr, bus_last);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_d_read();
        d_rw  = 2'b10;
        d_adr = 32'h8000_1040;
        push_line(1'b0, 2'b10, d_adr);
        @(negedge clk);
        expect_burst("d_read", -1, 0, -1);
    endtask

    task automatic test_both_pending();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        d_rw  = 2'b10;
        d_adr = 32'h0000_2000;
        i_rw  = 2'b10;
        i_adr = 32'h1234_5680;
        push_line(1'b0, 2'b10, d_adr);
        push_line(1'b1, 2'b10, i_adr);
        @(negedge clk);
        expect_burst("both_d_first", -1, 0, -1);
        @(negedge clk);
        expect_burst("both_i_second", -1, 0, -1);
    endtask

    task automatic test_stall();
        d_rw  = 2'b01;
        d_adr = 32'hA000_0100;
        push_line(1'b0, 2'b01, d_adr);
        @(negedge clk);
        expect_burst("stall_beat2", 2, 3, -1);
    endtask

    task automatic test_flush();
        flush = 1'b1;
        i_rw  = 2'b10;
        i_adr = 32'h0000_0FC0;
        push_line(1'b1, 2'b10, i_adr);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus_rw !== 2'b00 || grant_i !== 1'b0 || grant_d !== 1'b0) begin
                bad++;
                $display("FAIL flush_hold%0d: got rw=%b gi=%b gd=%b, required 00 0 0", c, bus_rw, grant_i, grant_d);
            end
        end
        flush = 1'b0;
        @(negedge clk);
        expect_burst("flush_release", -1, 0, 3);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        d_rw  = 2'b10;
        d_adr = 32'h4000_0A80;
        push_line(1'b0, 2'b10, d_adr);
        ready = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            total++;
            if (beat_cnt !== 3'(b) || bus_adr !== sb[0].adr) begin
                bad++;
                $display("FAIL rstmid_beat%0d: got cnt=%0d adr=%h, required cnt=%0d adr=%h", b, beat_cnt, bus_adr, b, sb[0].adr);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        total++;
        if (beat_cnt !== 3'd3) begin bad++; $display("FAIL rstmid_at3: got cnt=%0d, required 3", beat_cnt); end
        reset = 1'b1;
        #1;
        total++;
        if (bus_rw !== 2'b00 || grant_d !== 1'b0 || beat_cnt !== 3'd0 || d_ack !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: got rw=%b gd=%b cnt=%0d dack=%b, required 00 0 0 0", bus_rw, grant_d, beat_cnt, d_ack);
        end
        @(negedge clk);
        total++;
        if (d_ack !== 1'b0 || i_ack !== 1'b0 || grant_d !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_noack: got dack=%b iack=%b gd=%b, required 0 0 0", d_ack, i_ack, grant_d);
        end
        ready = 1'b0;
        sb.delete();
        push_line(1'b0, 2'b10, d_adr);
        reset = 1'b0;
        @(negedge clk);
        expect_burst("rstmid_restart", -1, 0, -1);
    endtask

    initial begin
        reset = 1'b1;
        d_rw  = 2'b00;
        d_adr = 32'h0;
        i_rw  = 2'b00;
        i_adr = 32'h0;
        flush = 1'b0;
        ready = 1'b0;
        test_reset();
        test_d_read();
        test_both_pending();
        test_stall();
        test_flush();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
